// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, ALUOp and mux-select encodings for the multi-cycle MIPS control path
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC     = 4'd6,
    RWB      = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    IEXEC    = 4'd10,
    IWB      = 4'd11,
    START    = 4'hF
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  function automatic logic is_mem_state(state_t s);
    return s inside {FETCH, MEMREAD, MEMWRITE};
  endfunction
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle MIPS datapath with a bounded memory-wait timeout
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluInstruct,
  output logic [1:0] pcSource,
  output logic       illegalOp,
  output logic       memFault,
  output logic [3:0] state
);
  state_t cur;
  logic [7:0] wait_cnt;
  logic waiting, timeout, legal;
  assign waiting = is_mem_state(cur) && !memReady;
  assign timeout = waiting && (MEM_TIMEOUT != 0) && (wait_cnt == 8'(MEM_TIMEOUT - 1));
  assign legal = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  assign state = cur;
  // Any exit from a wait, including a timeout retry of FETCH, restarts the count.
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      cur <= START;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= (waiting && !timeout) ? wait_cnt + 8'd1 : '0;
      case (cur)
        START:    cur <= FETCH;
        FETCH:    cur <= memReady ? DECODE : FETCH;
        DECODE:
          case (opcode)
            OP_LW, OP_SW: cur <= MEMADDR;
            OP_RTYPE:     cur <= EXEC;
            OP_BEQ:       cur <= BRANCH;
            OP_J:         cur <= JUMP;
            OP_ADDI:      cur <= IEXEC;
            default:      cur <= FETCH;
          endcase
        MEMADDR:  cur <= (opcode == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  cur <= memReady ? MEMWB : timeout ? FETCH : MEMREAD;
        MEMWRITE: cur <= (memReady || timeout) ? FETCH : MEMWRITE;
        EXEC:     cur <= RWB;
        IEXEC:    cur <= IWB;
        default:  cur <= FETCH;
      endcase
    end
  always_comb begin
    pcWrite = 1'b0;
    pcWriteCond = 1'b0;
    iorD = 1'b0;
    memRead = 1'b0;
    memWrite = 1'b0;
    irWrite = 1'b0;
    memToReg = 1'b0;
    regDst = 1'b0;
    regWrite = 1'b0;
    aluSrcA = 1'b0;
    aluSrcB = SRCB_REGB;
    aluInstruct = ALUOP_ADD;
    pcSource = PCSRC_ALU;
    illegalOp = (cur == DECODE) && !legal;
    memFault = timeout;
    case (cur)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
      end
      DECODE:   aluSrcB = SRCB_IMMSH;
      MEMADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        memRead = 1'b1;
        iorD = 1'b1;
      end
      MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      MEMWRITE: begin
        memWrite = 1'b1;
        iorD = 1'b1;
      end
      EXEC: begin
        aluSrcA = 1'b1;
        aluInstruct = ALUOP_FUNCT;
      end
      RWB: begin
        regWrite = 1'b1;
        regDst = 1'b1;
      end
      BRANCH: begin
        aluSrcA = 1'b1;
        aluInstruct = ALUOP_SUB;
        pcWriteCond = 1'b1;
        pcSource = PCSRC_ALUOUT;
      end
      JUMP: begin
        pcWrite = 1'b1;
        pcSource = PCSRC_JUMP;
      end
      IEXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        aluInstruct = ALUOP_IMM;
      end
      IWB:      regWrite = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: cycle-by-cycle scoreboard of state and decoded outputs against the control table
module tb_multicycle_control;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_fault;
  } ob_t;
  typedef struct packed {
    logic [3:0] st;
    ob_t        ob;
  } exp_t;
  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic [5:0] opcode = '0;
  logic memReady = 1'b1;
  logic pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite, aluSrcA;
  logic illegalOp, memFault;
  logic [1:0] aluSrcB, aluInstruct, pcSource;
  logic [3:0] state;
  ob_t dut_ob;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rstN(rstN), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluInstruct(aluInstruct),
    .pcSource(pcSource), .illegalOp(illegalOp), .memFault(memFault), .state(state)
  );
  assign dut_ob = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst,
                   regWrite, aluSrcA, aluSrcB, aluInstruct, pcSource, illegalOp, memFault};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic ob_t exp_ob(input logic [3:0] st, input logic rdy, input logic ill, input logic flt);
    ob_t o;
    o = '0;
    case (st)
      4'd0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      4'd1: o.alu_src_b = 2'b11;
      4'd2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd3: begin o.mem_read = 1; o.ior_d = 1; end
      4'd4: begin o.reg_write = 1; o.mem_to_reg = 1; end
      4'd5: begin o.mem_write = 1; o.ior_d = 1; end
      4'd6: begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      4'd7: begin o.reg_write = 1; o.reg_dst = 1; end
      4'd8: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
      4'd9: begin o.pc_write = 1; o.pc_source = 2'b10; end
      4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b11; end
      4'd11: o.reg_write = 1;
      default: ;
    endcase
    o.illegal_op = ill;
    o.mem_fault = flt;
    return o;
  endfunction
  // Drive one cycle's inputs, queue the expected state/outputs, and compare before the next rising edge.
  task automatic step(input string tag, input logic [5:0] opc, input logic rdy, input logic [3:0] es,
                      input logic ill = 1'b0, input logic flt = 1'b0);
    exp_t e;
    @(negedge clk);
    opcode = opc;
    memReady = rdy;
    sb.push_back('{st: es, ob: exp_ob(es, rdy, ill, flt)});
    #1;
    e = sb.pop_front();
    chk({tag, ".state"}, 32'(state), 32'(e.st));
    chk({tag, ".outs"}, 32'(dut_ob), 32'(e.ob));
  endtask
  initial begin
    #1 rstN = 1'b0;
    for (int i = 0; i < 3; i++) step("reset", 6'b000000, 1'b1, 4'hF);
    rstN = 1'b1;
    step("r.fetch", 6'b000000, 1'b1, 4'd0);
    step("r.decode", 6'b000000, 1'b1, 4'd1);
    step("r.exec", 6'b000000, 1'b1, 4'd6);
    step("r.rwb", 6'b000000, 1'b1, 4'd7);
    step("lw.fetch", 6'b100011, 1'b1, 4'd0);
    step("lw.decode", 6'b100011, 1'b1, 4'd1);
    step("lw.addr", 6'b100011, 1'b1, 4'd2);
    step("lw.wait0", 6'b100011, 1'b0, 4'd3);
    step("lw.wait1", 6'b100011, 1'b0, 4'd3);
    step("lw.done", 6'b100011, 1'b1, 4'd3);
    step("lw.wb", 6'b100011, 1'b1, 4'd4);
    step("sw.fetch", 6'b101011, 1'b1, 4'd0);
    step("sw.decode", 6'b101011, 1'b1, 4'd1);
    step("sw.addr", 6'b101011, 1'b1, 4'd2);
    step("sw.write", 6'b101011, 1'b1, 4'd5);
    step("beq.fetch", 6'b000100, 1'b1, 4'd0);
    step("beq.decode", 6'b000100, 1'b1, 4'd1);
    step("beq.branch", 6'b000100, 1'b1, 4'd8);
    step("j.fetch", 6'b000010, 1'b1, 4'd0);
    step("j.decode", 6'b000010, 1'b1, 4'd1);
    step("j.jump", 6'b000010, 1'b1, 4'd9);
    step("addi.fetch", 6'b001000, 1'b1, 4'd0);
    step("addi.decode", 6'b001000, 1'b1, 4'd1);
    step("addi.iexec", 6'b001000, 1'b1, 4'd10);
    step("addi.iwb", 6'b001000, 1'b1, 4'd11);
    step("ill.fetch", 6'b111111, 1'b1, 4'd0);
    step("ill.decode", 6'b111111, 1'b1, 4'd1, 1'b1);
    step("ill.after", 6'b111111, 1'b1, 4'd0);
    step("swto.decode", 6'b101011, 1'b1, 4'd1);
    step("swto.addr", 6'b101011, 1'b1, 4'd2);
    for (int i = 0; i < 3; i++) step("swto.wait", 6'b101011, 1'b0, 4'd5);
    step("swto.fault", 6'b101011, 1'b0, 4'd5, 1'b0, 1'b1);
    step("swto.fetch", 6'b101011, 1'b1, 4'd0);
    step("swlate.decode", 6'b101011, 1'b1, 4'd1);
    step("swlate.addr", 6'b101011, 1'b1, 4'd2);
    for (int i = 0; i < 3; i++) step("swlate.wait", 6'b101011, 1'b0, 4'd5);
    step("swlate.ready", 6'b101011, 1'b1, 4'd5);
    for (int i = 0; i < 3; i++) step("fto.wait", 6'b000000, 1'b0, 4'd0);
    step("fto.fault", 6'b000000, 1'b0, 4'd0, 1'b0, 1'b1);
    step("fto.retry", 6'b000000, 1'b0, 4'd0);
    step("fto.ready", 6'b000000, 1'b1, 4'd0);
    step("fto.decode", 6'b100011, 1'b1, 4'd1);
    step("arst.addr", 6'b100011, 1'b1, 4'd2);
    step("arst.wait0", 6'b100011, 1'b0, 4'd3);
    step("arst.wait1", 6'b100011, 1'b0, 4'd3);
    #2 rstN = 1'b0;
    #1;
    chk("arst.state", 32'(state), 32'hF);
    chk("arst.memread", 32'(memRead), 32'd0);
    step("arst.hold", 6'b000000, 1'b0, 4'hF);
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) step("arst.cnt", 6'b000000, 1'b0, 4'd0);
    step("arst.fault", 6'b000000, 1'b0, 4'd0, 1'b0, 1'b1);
    step("arst.fetch", 6'b000000, 1'b1, 4'd0);
    step("arst.decode", 6'b000000, 1'b1, 4'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
